pattern_detect: RTL and testbench

PATTERN_DETECT -- requirements
Module: pattern_detect

---
 rtl/pattern_detect_pkg.sv | 8 +
 rtl/pattern_detect_bit_history.sv | 46 ++++
 rtl/pattern_detect.sv | 82 ++++++++
 tb/tb_pattern_detect.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/pattern_detect_pkg.sv
// Shared types and default patterns for the serial pattern detector.
package pattern_detect_pkg;
   typedef enum logic [1:0] {EMPTY = 2'd0, FILLING = 2'd1, ARMED = 2'd2} state_t;

   localparam int               DEF_W     = 3;
   localparam logic [DEF_W-1:0] DEF_PAT_A = 3'b010;
   localparam logic [DEF_W-1:0] DEF_PAT_B = 3'b101;
endpackage

// File: rtl/pattern_detect_bit_history.sv
// W-bit shift window plus saturating fill level; window/full show the post-shift view of this cycle.
// Zero latency on the outputs; no backpressure (a bit is taken whenever shift_i is high).
module bit_history #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clear_i,
   input  logic         shift_i,
   input  logic         flush_i,
   input  logic         bit_i,
   output logic [W-1:0] window,
   output logic         full
);
   localparam int             FW       = $clog2(W + 1);
   localparam logic [FW-1:0]  FILL_MAX = FW'(W);

   logic [W-1:0]  win_q, win_d, win_shift;
   logic [FW-1:0] fill_q, fill_d, fill_inc;

   assign win_shift = {win_q[W-2:0], bit_i};
   assign fill_inc  = (shift_i && fill_q != FILL_MAX) ? fill_q + 1'b1 : fill_q;

   // Flush must not feed back into full, since flush is derived from a match on it.
   assign window = shift_i ? win_shift : win_q;
   assign full   = (fill_inc == FILL_MAX);

   always_comb begin
      win_d  = shift_i ? win_shift : win_q;
      fill_d = flush_i ? '0 : fill_inc;
      if (clear_i) begin
         win_d  = '0;
         fill_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_q  <= '0;
         fill_q <= '0;
      end else begin
         win_q  <= win_d;
         fill_q <= fill_d;
      end
   end
endmodule

// File: rtl/pattern_detect.sv
// Serial two-pattern detector with saturating match counter.
// Match pulses are registered one cycle after the accepting edge; no backpressure, clear wins over in_valid.
module pattern_detect
   import pattern_detect_pkg::*;
#(
   parameter int           W       = DEF_W,
   parameter logic [W-1:0] PAT_A   = W'(DEF_PAT_A),
   parameter logic [W-1:0] PAT_B   = W'(DEF_PAT_B),
   parameter int           OVERLAP = 1,
   parameter int           CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic             in_bit,
   input  logic             clear,
   output logic             match_a,
   output logic             match_b,
   output logic             match,
   output logic [CNT_W-1:0] count,
   output logic             count_sat
);
   state_t           state_q;
   logic             match_a_q, match_b_q;
   logic [CNT_W-1:0] count_q;

   logic [W-1:0] window;
   logic         full, accept, armed, hit_a, hit_b, hit, flush;

   assign accept = in_valid & ~clear;

   // Already armed, or this accepted bit completes the window.
   assign armed = (state_q == ARMED) | full;
   assign hit_a = accept & armed & (window == PAT_A);
   assign hit_b = accept & armed & (window == PAT_B);
   assign hit   = hit_a | hit_b;
   assign flush = hit & (OVERLAP == 0);

   bit_history #(.W(W)) u_hist (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear_i (clear),
      .shift_i (accept),
      .flush_i (flush),
      .bit_i   (in_bit),
      .window  (window),
      .full    (full)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= EMPTY;
         match_a_q <= 1'b0;
         match_b_q <= 1'b0;
         count_q   <= '0;
      end else if (clear) begin
         state_q   <= EMPTY;
         match_a_q <= 1'b0;
         match_b_q <= 1'b0;
         count_q   <= '0;
      end else begin
         match_a_q <= hit_a;
         match_b_q <= hit_b;
         if (hit && count_q != '1)
            count_q <= count_q + 1'b1;
         if (accept) begin
            if (flush)
               state_q <= EMPTY;
            else if (full)
               state_q <= ARMED;
            else
               state_q <= FILLING;
         end
      end
   end

   assign match_a   = match_a_q;
   assign match_b   = match_b_q;
   assign match     = match_a_q | match_b_q;
   assign count     = count_q;
   assign count_sat = &count_q;
endmodule

// File: tb/tb_pattern_detect.sv
// Three detector instances (overlap, non-overlap, 2-bit counter) share stimulus and are checked against a bit-history model.
module tb_pattern_detect;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic in_valid = 1'b0;
   logic in_bit = 1'b0;
   logic clear = 1'b0;

   logic [2:0] ma, mb, mm, sat;
   logic [7:0] cnt0, cnt1;
   logic [1:0] cnt2;

   int checks = 0;
   int failures = 0;

   // Model state per instance: value of accepted bits, number of bits since last flush, expected outputs.
   int hv[3], hl[3], ea[3], eb[3], ec[3];
   int ov_cfg[3]  = '{1, 0, 1};
   int cmax_cfg[3] = '{255, 255, 3};

   always #5 clk = ~clk;

   pattern_detect #(.OVERLAP(1), .CNT_W(8)) dut_ov (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit), .clear(clear),
      .match_a(ma[0]), .match_b(mb[0]), .match(mm[0]), .count(cnt0), .count_sat(sat[0]));
   pattern_detect #(.OVERLAP(0), .CNT_W(8)) dut_no (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit), .clear(clear),
      .match_a(ma[1]), .match_b(mb[1]), .match(mm[1]), .count(cnt1), .count_sat(sat[1]));
   pattern_detect #(.OVERLAP(1), .CNT_W(2)) dut_sat (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit), .clear(clear),
      .match_a(ma[2]), .match_b(mb[2]), .match(mm[2]), .count(cnt2), .count_sat(sat[2]));

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < 3; c++) begin
         hv[c] = 0; hl[c] = 0; ea[c] = 0; eb[c] = 0; ec[c] = 0;
      end
   endtask

   task automatic model_step(input bit v, input bit b, input bit c_clr);
      if (c_clr) begin
         model_reset();
      end else begin
         for (int c = 0; c < 3; c++) begin
            ea[c] = 0; eb[c] = 0;
            if (v) begin
               hv[c] = (hv[c] * 2 + int'(b)) % 8;
               if (hl[c] < 3) hl[c]++;
               if (hl[c] == 3) begin
                  ea[c] = (hv[c] == 2) ? 1 : 0;
                  eb[c] = (hv[c] == 5) ? 1 : 0;
                  if (ea[c] != 0 || eb[c] != 0) begin
                     if (ec[c] < cmax_cfg[c]) ec[c]++;
                     if (ov_cfg[c] == 0) hl[c] = 0;
                  end
               end
            end
         end
      end
   endtask

   function automatic int cnt_of(input int c);
      case (c)
         0:       return int'(cnt0);
         1:       return int'(cnt1);
         default: return int'(cnt2);
      endcase
   endfunction

   task automatic check_all(input string tag);
      for (int c = 0; c < 3; c++) begin
         chk($sformatf("%s_a%0d", tag, c), int'(ma[c]), ea[c]);
         chk($sformatf("%s_b%0d", tag, c), int'(mb[c]), eb[c]);
         chk($sformatf("%s_m%0d", tag, c), int'(mm[c]), (ea[c] != 0 || eb[c] != 0) ? 1 : 0);
         chk($sformatf("%s_cnt%0d", tag, c), cnt_of(c), ec[c]);
         chk($sformatf("%s_sat%0d", tag, c), int'(sat[c]), (ec[c] == cmax_cfg[c]) ? 1 : 0);
      end
   endtask

   task automatic step(input string tag, input bit v, input bit b, input bit c_clr);
      @(negedge clk);
      in_valid = v; in_bit = b; clear = c_clr;
      @(posedge clk);
      model_step(v, b, c_clr);
      #1;
      check_all(tag);
   endtask

   task automatic bits(input string tag, input int n, input logic [15:0] seq);
      for (int i = n - 1; i >= 0; i--) step(tag, 1'b1, seq[i], 1'b0);
   endtask

   initial begin
      model_reset();
      #2 rst_n = 1'b0;
      #1 check_all("rst");
      @(negedge clk);
      #2 rst_n = 1'b1;

      // Overlap: 0,1,0,1,0 (oldest first)
      bits("ovl", 5, 16'b01010);
      chk("ovl_count", int'(cnt0), 3);
      step("idle", 1'b0, 1'b0, 1'b0);
      step("clr", 1'b0, 1'b0, 1'b1);

      // Non-overlap: 0,1,0,1,0,1
      bits("novl", 6, 16'b010101);
      chk("novl_count", int'(cnt1), 2);
      step("clr", 1'b0, 1'b0, 1'b1);

      // Valid gaps
      step("gap", 1'b1, 1'b0, 1'b0);
      repeat (2) step("gap_idle", 1'b0, 1'b1, 1'b0);
      step("gap", 1'b1, 1'b1, 1'b0);
      repeat (3) step("gap_idle", 1'b0, 1'b0, 1'b0);
      step("gap", 1'b1, 1'b0, 1'b0);
      chk("gap_match_a", int'(ma[0]), 1);
      step("gap_after", 1'b0, 1'b0, 1'b0);
      step("clr", 1'b0, 1'b0, 1'b1);

      // Clear beats a simultaneous valid bit
      bits("cpri", 2, 16'b01);
      step("cpri_clr", 1'b1, 1'b0, 1'b1);
      chk("cpri_count", int'(cnt0), 0);
      bits("cpri_post", 3, 16'b010);
      chk("cpri_match_a", int'(ma[0]), 1);
      step("clr", 1'b0, 1'b0, 1'b1);

      // Saturation of the 2-bit counter
      bits("satur", 7, 16'b0101010);
      chk("sat_count", int'(cnt2), 3);
      chk("sat_flag", int'(sat[2]), 1);
      chk("sat_pulse", int'(ma[2]), 1);
      step("clr", 1'b0, 1'b0, 1'b1);

      // Reset mid-stream, between edges
      bits("mrst", 2, 16'b01);
      @(negedge clk);
      in_valid = 1'b0;
      #1 rst_n = 1'b0;
      model_reset();
      #1 check_all("mrst_async");
      #1 rst_n = 1'b1;
      step("mrst_b0", 1'b1, 1'b0, 1'b0);
      chk("mrst_nomatch", int'(mm[0]), 0);
      bits("mrst_post", 2, 16'b10);
      chk("mrst_match_a", int'(ma[0]), 1);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         step("rnd", ($urandom_range(0, 3) != 0), 1'($urandom & 1),
              ($urandom_range(0, 40) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
